// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
// Round-robin arbiter sharing one self-timed adder stage among N_REQ clocked
// clients. Clients talk 2-phase (toggle) req/ack; the stage input side is
// 2-phase (st_req/st_ack), the stage output side is 4-phase
// (st_done/st_done_ack). Stage handshake inputs are double-flop synchronised.
// A per-phase watchdog aborts a stuck operation and raises a sticky err.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cl_req/cl_ack   per-client 2-phase request / acknowledge
//   cl_data         client operands, client i at [i*WIDTH +: WIDTH]
//   res_data/res_id result and owning client, valid while res_valid pulses
//   res_valid       one-cycle result strobe
//   st_req/st_ack   stage input handshake (2-phase), st_ack asynchronous
//   st_in           operand presented to the stage
//   st_out          stage result, stable while st_done is high
//   st_done         stage result-ready level (asynchronous)
//   st_done_ack     4-phase acknowledge back to the stage
//   err             sticky timeout flag
// ---------------------------------------------------------------------------
module adder_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           cl_req,
    output logic [N_REQ-1:0]           cl_ack,
    input  logic [N_REQ*WIDTH-1:0]     cl_data,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_valid,
    output logic                       st_req,
    input  logic                       st_ack,
    output logic [WIDTH-1:0]           st_in,
    input  logic [WIDTH-1:0]           st_out,
    input  logic                       st_done,
    output logic                       st_done_ack,
    output logic                       err
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   grant_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;

    logic [N_REQ-1:0]  cl_ack_d;
    logic [WIDTH-1:0]  res_data_d;
    logic [ID_W-1:0]   res_id_d;
    logic              res_valid_d;
    logic              st_req_d;
    logic [WIDTH-1:0]  st_in_d;
    logic              st_done_ack_d;
    logic              err_d;

    logic              ack_s1;
    logic              ack_s;
    logic              done_s1;
    logic              done_s;

    logic [N_REQ-1:0]  pending_c;
    logic              any_pending_c;
    logic [ID_W-1:0]   grant_sel_c;
    logic [ID_W-1:0]   ptr_next_c;
    logic              tmo_c;
    logic              ack_match_c;

    logic [WIDTH-1:0]  cl_word [N_REQ];

    // Unpack the flat operand bus into one word per client
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign cl_word[gi] = cl_data[gi*WIDTH +: WIDTH];
    end

    // Double-flop synchronisers for the stage's asynchronous handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s1  <= 1'b0;
            ack_s   <= 1'b0;
            done_s1 <= 1'b0;
            done_s  <= 1'b0;
        end else begin
            ack_s1  <= st_ack;
            ack_s   <= ack_s1;
            done_s1 <= st_done;
            done_s  <= done_s1;
        end
    end

    assign pending_c     = cl_req ^ cl_ack;
    assign any_pending_c = |pending_c;
    assign tmo_c         = (timer_q == TMR_W'(TIMEOUT - 1));
    assign ack_match_c   = (ack_s == st_req);
    assign ptr_next_c    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    // Round-robin pick: first pending client at or after ptr, wrapping
    always_comb begin : p_grant
        int unsigned idx;
        logic        found;
        idx         = 0;
        found       = 1'b0;
        grant_sel_c = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && pending_c[ID_W'(idx)]) begin
                found       = 1'b1;
                grant_sel_c = ID_W'(idx);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; every wait state falls back to IDLE on timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_pending_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_match_c) begin
                    state_d = WAIT_DONE;
                end else if (tmo_c) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done_s) begin
                    state_d = RELEASE;
                end else if (tmo_c) begin
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                if (!done_s) begin
                    state_d = IDLE;
                end else if (tmo_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM output logic: next values for every registered output and datapath reg
    always_comb begin
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        timer_d       = '0;
        cl_ack_d      = cl_ack;
        res_data_d    = res_data;
        res_id_d      = res_id;
        res_valid_d   = 1'b0;
        st_req_d      = st_req;
        st_in_d       = st_in;
        st_done_ack_d = st_done_ack;
        err_d         = err;

        // Timer runs only while parked in a wait state; any state change restarts it
        if ((state_q == WAIT_ACK || state_q == WAIT_DONE || state_q == RELEASE) &&
            (state_d == state_q)) begin
            timer_d = timer_q + TMR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (any_pending_c) begin
                    grant_d = grant_sel_c;
                    st_in_d = cl_word[grant_sel_c];
                end
            end
            ISSUE: begin
                st_req_d = ~st_req;
            end
            WAIT_ACK: begin
                if (!ack_match_c && tmo_c) begin
                    err_d         = 1'b1;
                    st_done_ack_d = 1'b0;
                    ptr_d         = ptr_next_c;
                end
            end
            WAIT_DONE: begin
                if (done_s) begin
                    res_data_d    = st_out;
                    st_done_ack_d = 1'b1;
                end else if (tmo_c) begin
                    err_d         = 1'b1;
                    st_done_ack_d = 1'b0;
                    ptr_d         = ptr_next_c;
                end
            end
            RELEASE: begin
                if (!done_s) begin
                    st_done_ack_d = 1'b0;
                    cl_ack_d      = cl_ack ^ (N_REQ'(1) << grant_q);
                    res_id_d      = grant_q;
                    res_valid_d   = 1'b1;
                    ptr_d         = ptr_next_c;
                end else if (tmo_c) begin
                    err_d         = 1'b1;
                    st_done_ack_d = 1'b0;
                    ptr_d         = ptr_next_c;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            timer_q     <= '0;
            cl_ack      <= '0;
            res_data    <= '0;
            res_id      <= '0;
            res_valid   <= 1'b0;
            st_req      <= 1'b0;
            st_in       <= '0;
            st_done_ack <= 1'b0;
            err         <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            timer_q     <= timer_d;
            cl_ack      <= cl_ack_d;
            res_data    <= res_data_d;
            res_id      <= res_id_d;
            res_valid   <= res_valid_d;
            st_req      <= st_req_d;
            st_in       <= st_in_d;
            st_done_ack <= st_done_ack_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
// Drives adder_arbiter with a behavioural self-timed stage (adds stg_add,
// configurable done delay, can be broken to never acknowledge) and checks
// service order, results and acks against a round-robin reference.
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     cl_req;
    logic [N-1:0]     cl_ack;
    logic [N*W-1:0]   cl_data;
    logic [W-1:0]     res_data;
    logic [1:0]       res_id;
    logic             res_valid;
    logic             st_req;
    logic             st_ack  = 1'b0;
    logic [W-1:0]     st_in;
    logic [W-1:0]     st_out  = '0;
    logic             st_done = 1'b0;
    logic             st_done_ack;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = 0;

    // Stage model controls and state
    bit         stg_broken = 1'b0;
    logic [7:0] stg_add    = 8'd1;
    int         stg_dly    = 0;
    int         stg_ph     = 0;
    int         stg_cnt    = 0;
    logic       stg_prev   = 1'b0;

    adder_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cl_req      (cl_req),
        .cl_ack      (cl_ack),
        .cl_data     (cl_data),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_valid   (res_valid),
        .st_req      (st_req),
        .st_ack      (st_ack),
        .st_in       (st_in),
        .st_out      (st_out),
        .st_done     (st_done),
        .st_done_ack (st_done_ack),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural self-timed adder stage, reset together with the arbiter
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            st_ack   = 1'b0;
            st_done  = 1'b0;
            st_out   = '0;
            stg_ph   = 0;
            stg_cnt  = 0;
            stg_prev = 1'b0;
        end else begin
            case (stg_ph)
                0: begin
                    if (!stg_broken && st_req != stg_prev) begin
                        st_ack = st_req;
                        if (stg_dly == 0) begin
                            st_out  = st_in + stg_add;
                            st_done = 1'b1;
                            stg_ph  = 2;
                        end else begin
                            stg_cnt = stg_dly;
                            stg_ph  = 1;
                        end
                    end
                end
                1: begin
                    stg_cnt = stg_cnt - 1;
                    if (stg_cnt == 0) begin
                        st_out  = st_in + stg_add;
                        st_done = 1'b1;
                        stg_ph  = 2;
                    end
                end
                2: begin
                    if (st_done_ack) begin
                        st_done = 1'b0;
                        stg_ph  = 3;
                    end
                end
                default: begin
                    if (!st_done_ack) stg_ph = 0;
                end
            endcase
            stg_prev = st_req;
        end
    end

    // Waits (bounded) for the next result strobe and returns what it carried
    task automatic collect(input int budget, output bit got,
                           output logic [1:0] id, output logic [7:0] data);
        got  = 1'b0;
        id   = '0;
        data = '0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                got  = 1'b1;
                id   = res_id;
                data = res_data;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        cl_req  = '0;
        cl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cl_ack !== 4'h0) begin n_bad++; $display("FAIL reset_cl_ack got=%h exp=0", cl_ack); end
        n_cmp++; if (res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 2'd0) begin
            n_bad++; $display("FAIL reset_res got v=%b d=%h id=%0d exp 0/00/0", res_valid, res_data, res_id);
        end
        n_cmp++; if (st_req !== 1'b0 || st_in !== 8'h00 || st_done_ack !== 1'b0) begin
            n_bad++; $display("FAIL reset_stage got req=%b in=%h dack=%b exp 0/00/0", st_req, st_in, st_done_ack);
        end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        #2 rst = 1'b0;
        model_ptr = 0;
        @(posedge clk); #1;
    endtask

    // Toggle a set of clients at once and check they are served in rr order
    task automatic serve_batch(input logic [3:0] mask, input logic [31:0] data_word,
                               input logic [7:0] add, input int dly, input string tag);
        int         exp_q[$];
        bit         got;
        logic [1:0] id;
        logic [7:0] data;
        logic [7:0] exp_d;
        int         e;
        stg_add = add;
        stg_dly = dly;
        for (int k = 0; k < 4; k++) begin
            if (mask[(model_ptr + k) % 4]) exp_q.push_back((model_ptr + k) % 4);
        end
        cl_data = data_word;
        cl_req  = cl_req ^ mask;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_d = data_word[e*8 +: 8] + add;
            collect(300, got, id, data);
            n_cmp++;
            if (!got) begin
                n_bad++; $display("FAIL %s_timeout got=no result exp id=%0d", tag, e);
            end else begin
                if (id !== 2'(e)) begin n_bad++; $display("FAIL %s_id got=%0d exp=%0d", tag, id, e); end
                n_cmp++;
                if (data !== exp_d) begin n_bad++; $display("FAIL %s_data got=%h exp=%h", tag, data, exp_d); end
                n_cmp++;
                if (cl_ack[e] !== cl_req[e]) begin
                    n_bad++; $display("FAIL %s_ack got=%b exp=%b (client %0d)", tag, cl_ack[e], cl_req[e], e);
                end
            end
            model_ptr = (e + 1) % 4;
        end
    endtask

    task automatic test_single();
        logic req0;
        req0 = st_req;
        serve_batch(4'b0001, 32'h0000_0005, 8'd1, 0, "single");
        n_cmp++; if (st_in !== 8'h05) begin n_bad++; $display("FAIL single_st_in got=%h exp=05", st_in); end
        n_cmp++; if (st_req !== ~req0) begin n_bad++; $display("FAIL single_st_req got=%b exp=%b", st_req, ~req0); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got=%b exp=0", err); end
    endtask

    task automatic test_all_four();
        serve_batch(4'b1111, 32'h4030_2010, 8'd1, 1, "all4");
    endtask

    task automatic test_wrap_order();
        serve_batch(4'b0010, 32'h0000_5500, 8'd1, 0, "wrap_a");
        serve_batch(4'b1001, 32'h7700_0066, 8'd1, 2, "wrap_b");
    endtask

    task automatic test_overflow();
        serve_batch(4'b0001, 32'h0000_00FF, 8'd1, 0, "ovf");
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            serve_batch(4'($urandom_range(1, 15)), $urandom, 8'($urandom), int'($urandom_range(0, 5)), "rand");
        end
    endtask

    task automatic test_timeout();
        int         n;
        bit         saw_res;
        bit         got;
        logic [1:0] id;
        logic [7:0] data;
        stg_broken = 1'b1;
        stg_dly    = 0;
        stg_add    = 8'd1;
        cl_data    = 32'h0033_0000;
        cl_req[2]  = ~cl_req[2];
        n = 0;
        saw_res = 1'b0;
        while (n < 40 && err !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (res_valid) saw_res = 1'b1;
        end
        n_cmp++; if (n != 18) begin n_bad++; $display("FAIL tmo_latency got=%0d exp=18 cycles", n); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got=%b exp=1", err); end
        n_cmp++; if (cl_ack[2] === cl_req[2]) begin n_bad++; $display("FAIL tmo_ack got=%b exp=%b", cl_ack[2], ~cl_req[2]); end
        n_cmp++; if (saw_res) begin n_bad++; $display("FAIL tmo_res_valid got=1 exp=0"); end
        stg_broken = 1'b0;
        collect(300, got, id, data);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL tmo_retry got=no result exp id=2");
        end else if (id !== 2'd2 || data !== 8'h34) begin
            n_bad++; $display("FAIL tmo_retry got id=%0d d=%h exp id=2 d=34", id, data);
        end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got=%b exp=1", err); end
        n_cmp++; if (cl_ack[2] !== cl_req[2]) begin n_bad++; $display("FAIL tmo_retry_ack got=%b exp=%b", cl_ack[2], cl_req[2]); end
        model_ptr = 3;
    endtask

    task automatic test_reset_mid_op();
        int         c;
        int         exp_q[$];
        int         e;
        bit         got;
        logic [1:0] id;
        logic [7:0] data;
        logic [7:0] exp_d;
        logic [31:0] dw;
        if (cl_req == 4'hF) serve_batch(4'b0001, 32'h0000_0001, 8'd1, 0, "prep");
        c = 0;
        while (cl_req[c] == 1'b1) c++;
        dw = cl_data;
        dw[c*8 +: 8] = 8'h40;
        cl_data   = dw;
        stg_add   = 8'd2;
        stg_dly   = 30;
        cl_req[c] = 1'b1;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (cl_ack !== 4'h0 || res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 2'd0) begin
            n_bad++; $display("FAIL rstmid_res got ack=%h v=%b d=%h id=%0d exp all 0", cl_ack, res_valid, res_data, res_id);
        end
        n_cmp++; if (st_req !== 1'b0 || st_in !== 8'h00 || st_done_ack !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_stage got req=%b in=%h dack=%b err=%b exp all 0", st_req, st_in, st_done_ack, err);
        end
        stg_dly = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < 4; i++) if (cl_req[i]) exp_q.push_back(i);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_d = dw[e*8 +: 8] + 8'd2;
            collect(300, got, id, data);
            n_cmp++;
            if (!got) begin
                n_bad++; $display("FAIL rstmid_reissue got=no result exp id=%0d", e);
            end else if (id !== 2'(e) || data !== exp_d) begin
                n_bad++; $display("FAIL rstmid_reissue got id=%0d d=%h exp id=%0d d=%h", id, data, e, exp_d);
            end
            model_ptr = (e + 1) % 4;
        end
        n_cmp++; if (cl_ack !== cl_req) begin n_bad++; $display("FAIL rstmid_acks got=%h exp=%h", cl_ack, cl_req); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got=%b exp=0", err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap_order();
        test_overflow();
        test_random();
        test_timeout();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the bench can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=time limit exp=completion");
        $fatal(1, "watchdog");
    end

endmodule
